// File: rtl/peripheral_dbg_soc_dii_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_dbg_soc_dii_arbiter
//  Brief    : Packet-level round-robin merge of PORTS DII flit streams onto a
//             single DII channel. Optional output skid buffer when
//             PERIPHERAL_DBG_SOC_DII_ARB_OUTREG_EN is defined.
//  Revision : 1.0
// ============================================================================
module peripheral_dbg_soc_dii_arbiter #(
   parameter int XLEN  = 64,
   parameter int PORTS = 2
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic [PORTS-1:0][XLEN-1:0] req_data,
   input  logic [PORTS-1:0]           req_last,
   input  logic [PORTS-1:0]           req_valid,
   output logic [PORTS-1:0]           req_ready,
   output logic [XLEN-1:0]            out_data,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PORTS-1:0]           grant,
   output logic                       busy
);

   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam logic [IW-1:0] C_LAST_IDX = IW'(PORTS - 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   logic [PORTS-1:0] r_grant;
   logic [IW-1:0]    r_rr_ptr;
   logic [IW-1:0]    r_gnt_idx;
   logic             r_busy;

   logic             w_any;
   logic [IW-1:0]    w_winner;
   logic [IW-1:0]    w_cand;
   logic             w_lock;
   logic             w_src_valid;
   logic             w_src_last;
   logic             w_accept;

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int ofs);
      int s;
      s = (int'(base) + ofs) % PORTS;
      return IW'(s);
   endfunction

   // Search starts just after the last-served index and wraps, so a sole
   // requester equal to rr_ptr is found last and still wins.
   always_comb begin
      w_any    = 1'b0;
      w_winner = r_rr_ptr;
      w_cand   = r_rr_ptr;
      for (int i = 1; i <= PORTS; i++) begin
         w_cand = wrap_idx(r_rr_ptr, i);
         if (!w_any && req_valid[w_cand]) begin
            w_any    = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   assign w_lock      = (r_state == LOCKED);
   assign w_src_valid = w_lock & req_valid[r_gnt_idx];
   assign w_src_last  = req_last[r_gnt_idx];

`ifdef PERIPHERAL_DBG_SOC_DII_ARB_OUTREG_EN
   logic [XLEN-1:0] r_bdata [2];
   logic [1:0]      r_blast;
   logic [1:0]      r_cnt;
   logic            r_wr;
   logic            r_rd;
   logic            w_nfull;
   logic            w_pop;

   // Ready depends only on registered fill level: no out_ready -> req_ready path.
   assign w_nfull   = (r_cnt != 2'd2);
   assign w_accept  = w_src_valid & w_nfull;
   assign w_pop     = out_valid & out_ready;
   assign req_ready = r_grant & {PORTS{w_nfull}};
   assign out_valid = (r_cnt != 2'd0);
   assign out_data  = out_valid ? r_bdata[r_rd] : '0;
   assign out_last  = out_valid & r_blast[r_rd];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cnt <= 2'd0;
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
      end else begin
         if (w_accept) r_wr <= ~r_wr;
         if (w_pop)    r_rd <= ~r_rd;
         r_cnt <= r_cnt + 2'(w_accept) - 2'(w_pop);
      end
   end

   always_ff @(posedge HCLK) begin
      if (w_accept) begin
         r_bdata[r_wr] <= req_data[r_gnt_idx];
         r_blast[r_wr] <= w_src_last;
      end
   end
`else
   assign w_accept  = w_src_valid & out_ready;
   assign req_ready = r_grant & {PORTS{out_ready}};
   assign out_valid = w_src_valid;
   assign out_data  = w_lock ? req_data[r_gnt_idx] : '0;
   assign out_last  = w_lock & w_src_last;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_rr_ptr  <= C_LAST_IDX;
         r_gnt_idx <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state   <= LOCKED;
                  r_grant   <= PORTS'(1) << w_winner;
                  r_gnt_idx <= w_winner;
                  r_busy    <= 1'b1;
               end
            end
            LOCKED: begin
               if (w_accept && w_src_last) begin
                  r_state  <= IDLE;
                  r_grant  <= '0;
                  r_rr_ptr <= r_gnt_idx;
                  r_busy   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant = r_grant;
   assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_dbg_soc_dii_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peripheral_dbg_soc_dii_arbiter
//  Brief    : Directed bench with a packet-level reference model of the
//             round-robin DII arbiter (default build, no output register).
//  Revision : 1.0
// ============================================================================
module tb_peripheral_dbg_soc_dii_arbiter;

   localparam int XLEN  = 64;
   localparam int PORTS = 2;

   logic                       HCLK      = 1'b0;
   logic                       HRESETn   = 1'b0;
   logic [PORTS-1:0][XLEN-1:0] src_data  = '0;
   logic [PORTS-1:0]           src_last  = '0;
   logic [PORTS-1:0]           src_valid = '0;
   logic [PORTS-1:0]           req_ready;
   logic [XLEN-1:0]            out_data;
   logic                       out_last;
   logic                       out_valid;
   logic                       out_ready = 1'b1;
   logic [PORTS-1:0]           grant;
   logic                       busy;

   peripheral_dbg_soc_dii_arbiter #(.XLEN(XLEN), .PORTS(PORTS)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .req_data  (src_data),
      .req_last  (src_last),
      .req_valid (src_valid),
      .req_ready (req_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [XLEN-1:0] data;
      logic            last;
      int              gap;
   } flit_t;

   typedef struct {
      int              src;
      logic [XLEN-1:0] data;
      logic            last;
      int              cyc;
   } xfer_t;

   flit_t            srcq [PORTS][$];
   int               hold [PORTS];
   logic [PORTS-1:0] fire = '0;
   xfer_t            xlog [$];
   int               cyc   = 0;
   int               owner = -1;
   int               ptr   = PORTS - 1;
   int               n_vec = 0;
   int               n_err = 0;

   task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int s, input logic [XLEN-1:0] d, input logic l, input int g);
      flit_t f;
      f.data = d;
      f.last = l;
      f.gap  = g;
      srcq[s].push_back(f);
   endtask

   task automatic wait_log(input int n, input string nm);
      int t = 0;
      while (xlog.size() < n && t < 200) begin
         @(posedge HCLK);
         #2;
         t++;
      end
      chk(nm, 64'(xlog.size() >= n), 64'd1);
   endtask

   task automatic chk_xfer(input string nm, input int i, input int s, input logic [XLEN-1:0] d);
      if (i < xlog.size()) begin
         chk({nm, ".src"}, 64'(xlog[i].src), 64'(s));
         chk({nm, ".data"}, xlog[i].data, d);
      end else begin
         chk({nm, ".present"}, 64'd0, 64'd1);
      end
   endtask

   task automatic chk_gap(input string nm, input int i, input int d);
      if (i + 1 < xlog.size())
         chk(nm, 64'(xlog[i+1].cyc - xlog[i].cyc), 64'(d));
      else
         chk({nm, ".present"}, 64'd0, 64'd1);
   endtask

   always @(posedge HCLK) cyc++;

   // Source drivers: a flit stays presented until it is accepted; the flit's
   // gap field holds valid low for that many cycles after it transfers.
   always @(posedge HCLK) begin
      flit_t f;
      #1;
      for (int s = 0; s < PORTS; s++) begin
         if (fire[s] && srcq[s].size() > 0) begin
            f       = srcq[s].pop_front();
            hold[s] = f.gap;
         end else if (hold[s] > 0) begin
            hold[s]--;
         end
         fire[s] = 1'b0;
         if (srcq[s].size() > 0 && hold[s] == 0) begin
            src_valid[s] = 1'b1;
            src_data[s]  = srcq[s][0].data;
            src_last[s]  = srcq[s][0].last;
         end else begin
            src_valid[s] = 1'b0;
            src_data[s]  = '0;
            src_last[s]  = 1'b0;
         end
      end
   end

   // Reference model: owner is the locked source (-1 when idle), ptr the
   // last-served source. Outputs are checked mid-cycle while inputs are stable.
   always @(negedge HCLK) begin
      logic [PORTS-1:0] e_grant;
      logic [PORTS-1:0] e_ready;
      logic             e_valid;
      logic             e_last;
      logic [XLEN-1:0]  e_data;
      xfer_t            x;
      int               c;
      e_grant = '0;
      e_ready = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_data  = '0;
      if (!HRESETn) begin
         owner = -1;
         ptr   = PORTS - 1;
      end else if (owner >= 0) begin
         e_grant[owner] = 1'b1;
         e_valid        = src_valid[owner];
         e_last         = src_last[owner];
         e_data         = src_data[owner];
         e_ready[owner] = out_ready;
      end
      chk("grant",     64'(grant),     64'(e_grant));
      chk("busy",      64'(busy),      64'(owner >= 0));
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("out_last",  64'(out_last),  64'(e_last));
      chk("out_data",  out_data,       e_data);
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      fire = src_valid & req_ready;
      if (HRESETn) begin
         if (owner < 0) begin
            for (int k = 1; k <= PORTS; k++) begin
               c = (ptr + k) % PORTS;
               if (owner < 0 && src_valid[c]) owner = c;
            end
         end else if (e_valid && out_ready) begin
            x.src  = owner;
            x.data = out_data;
            x.last = out_last;
            x.cyc  = cyc;
            xlog.push_back(x);
            if (e_last) begin
               ptr   = owner;
               owner = -1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      for (int s = 0; s < PORTS; s++) hold[s] = 0;

      // Idle after reset
      repeat (3) @(posedge HCLK);
      #2 HRESETn = 1'b1;
      repeat (10) @(posedge HCLK);
      #2;
      chk("idle.grant", 64'(grant), 64'd0);
      chk("idle.busy",  64'(busy),  64'd0);

      // Single 3-flit packet from source 0
      xlog.delete();
      push(0, 64'hA1, 1'b0, 0);
      push(0, 64'hA2, 1'b0, 0);
      push(0, 64'hA3, 1'b1, 0);
      @(posedge HCLK);
      #2 c0 = cyc;
      wait_log(3, "p3.wait");
      chk_xfer("p3.f0", 0, 0, 64'hA1);
      chk_xfer("p3.f1", 1, 0, 64'hA2);
      chk_xfer("p3.f2", 2, 0, 64'hA3);
      if (xlog.size() > 0) chk("p3.latency", 64'(xlog[0].cyc - c0), 64'd1);
      chk_gap("p3.gap01", 0, 1);
      chk_gap("p3.gap12", 1, 1);
      chk("p3.busy_after", 64'(busy), 64'd0);

      // Both sources back-to-back from reset
      HRESETn = 1'b0;
      repeat (2) @(posedge HCLK);
      #2 HRESETn = 1'b1;
      xlog.delete();
      for (int p = 0; p < 2; p++) begin
         push(0, 64'(8'hC0 + 2*p), 1'b0, 0);
         push(0, 64'(8'hC1 + 2*p), 1'b1, 0);
         push(1, 64'(8'hD0 + 2*p), 1'b0, 0);
         push(1, 64'(8'hD1 + 2*p), 1'b1, 0);
      end
      wait_log(8, "rr.wait");
      for (int i = 0; i < 8; i++) begin
         chk_xfer("rr.order", i, (i / 2) % 2,
                  64'(((i / 2) % 2 == 0 ? 8'hC0 : 8'hD0) + 2*(i / 4) + (i % 2)));
         if (i < 7) chk_gap("rr.gap", i, (i % 2 == 1) ? 2 : 1);
      end

      // Granted source stalls mid-packet; source 1 must wait
      xlog.delete();
      push(0, 64'hE1, 1'b0, 5);
      push(0, 64'hE2, 1'b0, 0);
      push(0, 64'hE3, 1'b1, 0);
      push(1, 64'hF1, 1'b1, 0);
      wait_log(4, "stall.wait");
      chk_xfer("stall.f0", 0, 0, 64'hE1);
      chk_xfer("stall.f1", 1, 0, 64'hE2);
      chk_xfer("stall.f2", 2, 0, 64'hE3);
      chk_xfer("stall.f3", 3, 1, 64'hF1);
      chk_gap("stall.hole", 0, 6);
      chk_gap("stall.bubble", 2, 2);

      // Backpressure with 0xB2 pending; sole requester equals rr_ptr
      xlog.delete();
      push(1, 64'hB1, 1'b0, 0);
      push(1, 64'hB2, 1'b0, 0);
      push(1, 64'hB3, 1'b1, 0);
      wait_log(1, "bp.wait1");
      out_ready = 1'b0;
      repeat (2) @(posedge HCLK);
      #2;
      chk("bp.hold_data",  out_data,         64'hB2);
      chk("bp.hold_valid", 64'(out_valid),   64'd1);
      repeat (2) @(posedge HCLK);
      #2 out_ready = 1'b1;
      wait_log(3, "bp.wait3");
      chk_xfer("bp.f1", 1, 1, 64'hB2);
      chk_xfer("bp.f2", 2, 1, 64'hB3);
      chk_gap("bp.stall", 0, 5);
      repeat (3) @(posedge HCLK);
      #2 chk("bp.once", 64'(xlog.size()), 64'd3);

      // Reset in the middle of source 1's packet
      xlog.delete();
      push(1, 64'h71, 1'b0, 0);
      push(1, 64'h72, 1'b0, 0);
      push(1, 64'h73, 1'b0, 0);
      push(1, 64'h74, 1'b1, 0);
      wait_log(1, "rst.wait1");
      push(0, 64'h51, 1'b1, 0);
      out_ready = 1'b0;
      #1 HRESETn = 1'b0;
      #1;
      chk("rst.grant",     64'(grant),     64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy",      64'(busy),      64'd0);
      srcq[1].delete();
      hold[1] = 0;
      repeat (2) @(posedge HCLK);
      #2;
      HRESETn   = 1'b1;
      out_ready = 1'b1;
      push(1, 64'h61, 1'b1, 0);
      wait_log(3, "rst.wait3");
      chk_xfer("rst.partial", 0, 1, 64'h71);
      chk_xfer("rst.first",   1, 0, 64'h51);
      chk_xfer("rst.resend",  2, 1, 64'h61);

      repeat (3) @(posedge HCLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
